// File: rtl/arb16_rr_ctrl.sv
// Sixteen-requester arbiter: fixed-priority or round-robin winner, one-hot grant held until release.
// Latency: grant registered one edge after a request is seen in IDLE; release takes one edge.
// Backpressure: none; requesters hold req until granted, owner releases via done/drop/hold limit.
module arb16_rr_ctrl #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mode,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_vld,
    output logic        timeout,
    output logic        idle
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_gnt;
    logic [3:0]  r_gnt_id;
    logic        r_gnt_vld;
    logic        r_timeout;
    logic [3:0]  r_last_id;
    logic [7:0]  r_hold_cnt;

    logic [3:0]  w_win_id;
    logic [3:0]  w_rr_idx;
    logic        w_req_own;
    logic        w_hold_hit;
    logic        w_grant;
    logic        w_release;
    logic        w_timeout_nxt;

    // Winner select: the last matching assignment in each loop is the highest-priority hit.
    always_comb begin
        w_win_id = 4'd0;
        w_rr_idx = 4'd0;
        if (mode) begin
            // Offset 16 wraps to last_id itself (lowest priority); offset 1 is last_id-1 (highest).
            for (int j = 16; j >= 1; j--) begin
                w_rr_idx = r_last_id - 4'(j);
                if (req[w_rr_idx]) begin
                    w_win_id = w_rr_idx;
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (req[i]) begin
                    w_win_id = 4'(i);
                end
            end
        end
    end

    // Next-state logic and release causes; timeout only when the hold limit is the sole cause.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_own     = req[r_gnt_id];
        w_hold_hit    = (r_hold_cnt == HOLD_LIM);
        w_grant       = 1'b0;
        w_release     = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && (req != 16'd0)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!en || !w_req_own || done || w_hold_hit) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = en && w_req_own && !done && w_hold_hit;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, index, round-robin pointer and hold counter; gnt_id is kept after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 16'd0;
            r_gnt_id   <= 4'd0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_last_id  <= 4'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (w_grant) begin
                r_gnt      <= 16'd1 << w_win_id;
                r_gnt_id   <= w_win_id;
                r_gnt_vld  <= 1'b1;
                r_last_id  <= w_win_id;
                r_hold_cnt <= 8'd1;
            end else if (w_release) begin
                r_gnt     <= 16'd0;
                r_gnt_vld <= 1'b0;
            end else if ((r_state == ST_BUSY) && (r_hold_cnt != 8'hFF)) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;
    assign idle    = (r_state == ST_IDLE) && (req == 16'd0);

endmodule

// File: doc/arb16_rr_ctrl.md
# arb16_rr_ctrl

Sixteen-requester arbiter that shares one downstream resource among masters `req[15:0]`. Winner selection is a priority encode: highest index wins in fixed mode, and a rotating search starting below the last winner in round-robin mode. The block holds a registered one-hot grant plus a 4-bit index until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the request lines and the shared resource's select/mux.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum BUSY cycles per grant. Legal range 1..255.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: arbiter enable. When 0, no new grant is issued and a held grant is released.
- `mode`, input, 1: 0 = fixed priority (index 15 highest); 1 = round-robin.
- `req`, input, 16: request vector, level-sensitive. A requester holds `req[i]` until it is granted.
- `done`, input, 1: current owner's transaction is complete. Sampled only in BUSY.
- `gnt`, output, 16: one-hot grant, registered.
- `gnt_id`, output, 4: encoded index of `gnt`, registered. Holds its last value when `gnt_vld`=0.
- `gnt_vld`, output, 1: high exactly when `gnt` is nonzero.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released by the hold limit.
- `idle`, output, 1: combinational; equals (state==IDLE) & ~|req.

## Operation
- State machine states: IDLE and BUSY.
- **IDLE**
  - If `en`=1 and `req`≠0, the winner w is computed combinationally.
  - Next edge: `gnt`←1<<w, `gnt_id`←w, `gnt_vld`←1, `last_id`←w, `hold_cnt`←1, state←BUSY.
  - Otherwise remain in IDLE with `gnt`=0.
- **BUSY** releases on the first true condition below, evaluated in priority order:
  - (a) `en`=0
  - (b) `req[gnt_id]`=0
  - (c) `done`=1
  - (d) `hold_cnt`==HOLD_MAX
- On release, the next edge sets `gnt`←0, `gnt_vld`←0, state←IDLE.
  - `timeout`←1 for one cycle only when (d) is the cause and (a)–(c) are all false.
  - Otherwise `hold_cnt`←`hold_cnt`+1, saturating at 255.
- **Fixed mode**: w = highest set index of `req`.
- **Round-robin mode**: search indices `last_id`-1, `last_id`-2, … down to 0, then 15 … `last_id`, with modulo-16 wrap. The first set bit wins. `last_id` itself has the lowest priority.
- `last_id` updates on every grant in both modes. Switching `mode` takes effect at the next arbitration only; it never disturbs a held grant.
- `req` changes during BUSY do not affect `gnt`, except rule (b).
- `gnt` is always one-hot or zero and always equals 1<<`gnt_id` while `gnt_vld`=1.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE; `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `timeout`=0.
  - `last_id`=0, so the first round-robin search starts at index 15; `hold_cnt`=0.
- Grant latency: `req` sampled in IDLE at edge k produces `gnt` valid after edge k.
- Grant duration:
  - `done` sampled high at the m-th BUSY cycle gives a grant of exactly m cycles.
  - With no release, the grant lasts HOLD_MAX cycles, and `timeout` is high in the first IDLE cycle.
- Release always passes through one IDLE cycle. Back-to-back grants are therefore separated by exactly one cycle with `gnt`=0; the minimum period is 2 cycles per grant.
- `en` falling in BUSY releases at the next edge. `en` low in IDLE blocks arbitration, and `idle` still reflects `req`.
- Simultaneous `done` and hold limit: the cause is (c), so `timeout` stays 0.
- `rst_n` asserted mid-grant: `gnt` clears immediately without waiting for a clock. After deassertion, arbitration resumes from `last_id`=0.
- HOLD_MAX=1: every grant lasts exactly 1 cycle. `timeout` pulses unless `done`=1 or the request dropped in that cycle.

## Test plan
- **Reset**: `rst_n`=0 mid-BUSY with `req`=16'hFFFF → `gnt`=0, `gnt_vld`=0, `gnt_id`=0 immediately. Release, `en`=1, `mode`=1 → first grant `gnt_id`=15 one cycle later.
- **Fixed priority**: `mode`=0, `req`=16'h0A10, `done` pulsed on the 2nd BUSY cycle each time → grant sequence 11, 11, 11, … with a one-cycle gap each time. Then `req`=16'h0010 → `gnt_id`=4, `gnt`=16'h0010.
- **Round-robin**: `mode`=1, `req`=16'h8421 held, `done`=1 every BUSY cycle → `gnt_id` sequence 15, 10, 5, 0, 15. Grants are 1 cycle each with 1-cycle gaps.
- **Hold limit**: HOLD_MAX=8, `req`=16'h0004 held, `done`=0 → `gnt` high exactly 8 cycles, then `timeout`=1 for 1 cycle, then re-grant to 2 after the gap. Repeat with `done`=1 on the 8th cycle → `timeout`=0.
- **Request drop and disable**:
  - Owner 3 drops `req[3]` on BUSY cycle 2 → `gnt`=0 next edge, `timeout`=0.
  - `en`=0 in BUSY → release next edge; no new grant while `en`=0.
  - `idle`=1 whenever in IDLE with `req`=0.
- **Mode switch mid-grant**: grant to 9 in `mode`=0, flip to `mode`=1 during BUSY → `gnt_id` stays 9 until release. With `req`=16'h0300, the next winner is 8.
